// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for NUM_REQ requesters with registered one-hot grant, grant-hold and
// optional hold-quantum preemption. Define RR_ARB_LOCK_EN to add the per-requester lock port.
module rr_arbiter_n #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned MAX_HOLD = 0,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
`ifdef RR_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               gnt_new
);

    localparam int unsigned HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic                gnt_new_q, gnt_new_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic                win_found_c;
    logic [ID_W-1:0]     win_id_c;
    logic                preempt_c;
    logic                locked_c;

    // First requester after base (wrapping), so base itself gets lowest priority
    function automatic logic [ID_W:0] rr_search(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    base);
        logic            found;
        logic [ID_W-1:0] id;
        logic [ID_W-1:0] cand;
        found = 1'b0;
        id    = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(base) + k) % NUM_REQ);
            if (!found && r[cand]) begin
                found = 1'b1;
                id    = cand;
            end
        end
        return {found, id};
    endfunction

`ifdef RR_ARB_LOCK_EN
    assign locked_c = lock[gnt_id_q];
`else
    assign locked_c = 1'b0;
`endif

    // Current owner is masked out so a preemption or release never re-picks it
    assign {win_found_c, win_id_c} = rr_search(req & ~gnt_q, last_q);

    assign preempt_c = (MAX_HOLD != 0) && ((32'(hold_q) + 32'd1) >= MAX_HOLD) && !locked_c;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        gnt_new_d   = 1'b0;
        last_d      = last_q;
        hold_d      = hold_q;

        unique case (state_q)
            IDLE: begin
                hold_d = '0;
                if (win_found_c) begin
                    state_d     = OWNED;
                    gnt_d       = NUM_REQ'(1) << win_id_c;
                    gnt_id_d    = win_id_c;
                    gnt_valid_d = 1'b1;
                    gnt_new_d   = 1'b1;
                    last_d      = win_id_c;
                end
            end
            OWNED: begin
                if (win_found_c && (!req[gnt_id_q] || preempt_c)) begin
                    gnt_d       = NUM_REQ'(1) << win_id_c;
                    gnt_id_d    = win_id_c;
                    gnt_new_d   = 1'b1;
                    last_d      = win_id_c;
                    hold_d      = '0;
                end else if (!req[gnt_id_q]) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    hold_d      = '0;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d      = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            gnt_new_q   <= 1'b0;
            last_q      <= ID_W'(NUM_REQ - 1);
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_new_q   <= gnt_new_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_new   = gnt_new_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Scoreboard bench for rr_arbiter_n: a cycle-level reference model pushes the expected
// outputs for each edge, an independent monitor pops and compares after every edge.
module tb_rr_arbiter_n;

    localparam int unsigned N    = 4;
    localparam int unsigned MAXH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         gnt_valid;
    logic         gnt_new;
`ifdef RR_ARB_LOCK_EN
    logic [N-1:0] lock;
`endif

    always #5 clk = ~clk;

    rr_arbiter_n #(.NUM_REQ(N), .MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
`ifdef RR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .gnt_new   (gnt_new)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [1:0]   id;
        logic         valid;
        logic         newp;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference state: owner (-1 = none), last winner, shown id, cycles the owner has held
    int   m_owner = -1;
    int   m_last  = N - 1;
    int   m_id    = 0;
    int   m_held  = 0;
    logic m_new   = 1'b0;

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    // Drive one cycle of inputs and push what the outputs must be after the next edge
    task automatic step(input logic r_rst, input logic [N-1:0] r_req, input logic [N-1:0] r_lock);
        logic need;
        logic lk;
        int   w;
        int   c;
        exp_t e;
        @(negedge clk);
        rst = r_rst;
        req = r_req;
        lk  = 1'b0;
`ifdef RR_ARB_LOCK_EN
        lock = r_lock;
        if (m_owner >= 0) lk = r_lock[m_owner];
`else
        if (r_lock != r_lock) lk = 1'b1;
`endif
        if (r_rst) begin
            m_owner = -1;
            m_last  = N - 1;
            m_id    = 0;
            m_held  = 0;
            m_new   = 1'b0;
        end else begin
            m_new = 1'b0;
            need  = 1'b0;
            if (m_owner < 0 || !r_req[m_owner]) begin
                need = 1'b1;
            end else if (MAXH > 0 && m_held >= MAXH && !lk &&
                         (r_req & ~(N'(1) << m_owner)) != '0) begin
                need = 1'b1;
            end
            if (need) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (w < 0 && c != m_owner && r_req[c]) w = c;
                end
                if (w >= 0) begin
                    m_owner = w;
                    m_last  = w;
                    m_id    = w;
                    m_held  = 1;
                    m_new   = 1'b1;
                end else begin
                    m_owner = -1;
                    m_held  = 0;
                end
            end else begin
                m_held++;
            end
        end
        e.gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e.id    = 2'(m_id);
        e.valid = (m_owner >= 0);
        e.newp  = m_new;
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",       32'(gnt),       32'(e.gnt));
                chk("gnt_id",    32'(gnt_id),    32'(e.id));
                chk("gnt_valid", 32'(gnt_valid), 32'(e.valid));
                chk("gnt_new",   32'(gnt_new),   32'(e.newp));
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] cur;
        rst = 1'b1;
        req = '0;
`ifdef RR_ARB_LOCK_EN
        lock = '0;
`endif
        // Reset then a single long request
        step(1'b1, '0, '0);
        step(1'b1, '0, '0);
        repeat (12) step(1'b0, 4'b0100, '0);
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);

        // Fairness: every owner drops its request right after being granted
        step(1'b1, '0, '0);
        repeat (10) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_held == 1) r[m_owner] = 1'b0;
            step(1'b0, r, '0);
        end

        // Pointer wrap
        for (int i = 0; i < 8 && m_owner != 3; i++) step(1'b0, 4'b1000, '0);
        step(1'b0, 4'b0011, '0);
        step(1'b0, 4'b1010, '0);
        step(1'b0, 4'b1010, '0);

        // Preemption, then a lone requester held indefinitely
        step(1'b1, '0, '0);
        step(1'b0, 4'b0001, '0);
        repeat (10) step(1'b0, 4'b0101, '0);
        repeat (14) step(1'b0, 4'b0001, '0);

`ifdef RR_ARB_LOCK_EN
        step(1'b1, '0, '0);
        repeat (20) step(1'b0, 4'b0011, 4'b0001);
        repeat (4) step(1'b0, 4'b0011, '0);
`endif

        // Reset in the middle of a grant
        for (int i = 0; i < 8 && m_owner != 3; i++) step(1'b0, 4'b1000, '0);
        step(1'b1, 4'b1111, '0);
        repeat (3) step(1'b0, 4'b1111, '0);

        // Randomized traffic with sticky requests and occasional reset
        cur = '0;
        repeat (400) begin
            if ($urandom_range(0, 1) == 1) cur = N'($urandom_range(0, 15));
            step(($urandom_range(0, 39) == 0), cur, N'($urandom_range(0, 15)));
        end

        repeat (2) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
